// File: rtl/vmem1_ctl_if.sv
// Bus bundle between the CPU map logic, the spy/debug port, the map RAM wrapper
// and the vmem1_ctl access controller.
interface vmem1_ctl_if #(
  parameter int ADR_W  = 10,
  parameter int DATA_W = 24
);
  logic              init_req;
  logic              init_busy;

  logic              cpu_wr_req;
  logic [ADR_W-1:0]  cpu_wr_adr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_wr_ack;

  logic              cpu_rd_req;
  logic [ADR_W-1:0]  cpu_rd_adr;
  logic              cpu_rd_ack;
  logic              cpu_rd_valid;

  logic              spy_req;
  logic              spy_we;
  logic [ADR_W-1:0]  spy_adr;
  logic [DATA_W-1:0] spy_wdata;
  logic              spy_ack;
  logic [DATA_W-1:0] spy_rdata;
  logic              spy_rvalid;

  logic [ADR_W-1:0]  mem_adr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_q;

  modport master (
    output init_req,
    output cpu_wr_req, cpu_wr_adr, cpu_wr_data,
    output cpu_rd_req, cpu_rd_adr,
    output spy_req, spy_we, spy_adr, spy_wdata,
    output mem_q,
    input  init_busy,
    input  cpu_wr_ack, cpu_rd_ack, cpu_rd_valid,
    input  spy_ack, spy_rdata, spy_rvalid,
    input  mem_adr, mem_wdata, mem_rd, mem_wr
  );

  modport slave (
    input  init_req,
    input  cpu_wr_req, cpu_wr_adr, cpu_wr_data,
    input  cpu_rd_req, cpu_rd_adr,
    input  spy_req, spy_we, spy_adr, spy_wdata,
    input  mem_q,
    output init_busy,
    output cpu_wr_ack, cpu_rd_ack, cpu_rd_valid,
    output spy_ack, spy_rdata, spy_rvalid,
    output mem_adr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/vmem1_ctl.sv
// Level-1 map RAM access controller: clear sweep plus a one-grant-per-cycle
// arbiter for CPU writes, CPU lookups and the spy port, with spy anti-starvation.
module vmem1_ctl #(
  parameter int ADR_W         = 10,
  parameter int DATA_W        = 24,
  parameter int STARVE_MAX    = 15,
  parameter int INIT_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  vmem1_ctl_if.slave  bus
);

  localparam int                SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [ADR_W-1:0]  LAST_ADR   = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? S_INIT : S_RUN;

  state_t            state;
  state_t            state_nx;
  logic [ADR_W-1:0]  sweep_cnt;
  logic [ADR_W-1:0]  sweep_nx;
  logic [SW-1:0]     starve_cnt;
  logic [SW-1:0]     starve_nx;
  logic [ADR_W-1:0]  adr_hold;
  logic [ADR_W-1:0]  adr_nx;
  logic [DATA_W-1:0] wdata_hold;
  logic [DATA_W-1:0] wdata_nx;
  logic [DATA_W-1:0] spy_rdata_hold;
  logic              cpu_rd_pend;
  logic              spy_rd_pend;
  logic              gnt_wr;
  logic              gnt_rd;
  logic              gnt_spy;
  logic              spy_starved;
  logic              mem_rd_c;
  logic              mem_wr_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET_STATE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sweep_cnt      <= '0;
      starve_cnt     <= '0;
      adr_hold       <= '0;
      wdata_hold     <= '0;
      cpu_rd_pend    <= 1'b0;
      spy_rd_pend    <= 1'b0;
      spy_rdata_hold <= '0;
    end else begin
      sweep_cnt   <= sweep_nx;
      starve_cnt  <= starve_nx;
      adr_hold    <= adr_nx;
      wdata_hold  <= wdata_nx;
      cpu_rd_pend <= gnt_rd;
      spy_rd_pend <= gnt_spy & ~bus.spy_we;
      if (spy_rd_pend) begin
        spy_rdata_hold <= bus.mem_q;
      end
    end
  end

  // Everything is gated by reset so the RAM sees no strobes while reset is held,
  // even though the state register already sits in INIT.
  always_comb begin
    state_nx    = state;
    sweep_nx    = sweep_cnt;
    starve_nx   = starve_cnt;
    adr_nx      = adr_hold;
    wdata_nx    = wdata_hold;
    gnt_wr      = 1'b0;
    gnt_rd      = 1'b0;
    gnt_spy     = 1'b0;
    mem_rd_c    = 1'b0;
    mem_wr_c    = 1'b0;
    spy_starved = bus.spy_req && (starve_cnt == STARVE_TOP);

    if (reset) begin
      case (state)
        S_INIT: begin
          mem_wr_c = 1'b1;
          adr_nx   = sweep_cnt;
          wdata_nx = '0;
          sweep_nx = sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADR) begin
            state_nx = S_RUN;
          end
        end
        S_RUN: begin
          if (spy_starved) begin
            gnt_spy = 1'b1;
          end else if (bus.cpu_wr_req) begin
            gnt_wr = 1'b1;
          end else if (bus.cpu_rd_req) begin
            gnt_rd = 1'b1;
          end else if (bus.spy_req) begin
            gnt_spy = 1'b1;
          end

          if (gnt_wr) begin
            mem_wr_c = 1'b1;
            adr_nx   = bus.cpu_wr_adr;
            wdata_nx = bus.cpu_wr_data;
          end else if (gnt_rd) begin
            mem_rd_c = 1'b1;
            adr_nx   = bus.cpu_rd_adr;
          end else if (gnt_spy) begin
            adr_nx = bus.spy_adr;
            if (bus.spy_we) begin
              mem_wr_c = 1'b1;
              wdata_nx = bus.spy_wdata;
            end else begin
              mem_rd_c = 1'b1;
            end
          end

          // The grant above still completes; the sweep starts on the next edge.
          if (bus.init_req) begin
            state_nx = S_INIT;
            sweep_nx = '0;
          end
        end
        default: begin
          state_nx = RESET_STATE;
        end
      endcase

      if (!bus.spy_req || gnt_spy) begin
        starve_nx = '0;
      end else if (state == S_RUN && starve_cnt != STARVE_TOP) begin
        starve_nx = starve_cnt + 1'b1;
      end
    end
  end

  assign bus.init_busy    = (state == S_INIT);
  assign bus.cpu_wr_ack   = gnt_wr;
  assign bus.cpu_rd_ack   = gnt_rd;
  assign bus.spy_ack      = gnt_spy;
  assign bus.cpu_rd_valid = cpu_rd_pend;
  assign bus.spy_rvalid   = spy_rd_pend;
  // Pass mem_q straight through in the pulse cycle so data and rvalid line up.
  assign bus.spy_rdata    = spy_rd_pend ? bus.mem_q : spy_rdata_hold;
  assign bus.mem_adr      = adr_nx;
  assign bus.mem_wdata    = wdata_nx;
  assign bus.mem_rd       = mem_rd_c;
  assign bus.mem_wr       = mem_wr_c;

endmodule
